// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared byte-enable encodings, error pattern and arbiter state type
package data_mem_pkg;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [31:0] BAD_BE_DATA = 32'hDEADBEEF;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic logic be_legal(input logic [3:0] be);
    return be == BE_BYTE || be == BE_HALF || be == BE_WORD;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting one past last_grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // walk from the farthest candidate to the nearest so the nearest hit wins
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N]) begin
        grant = '0;
        grant[(int'(last_grant) + k) % N] = 1'b1;
        idx = IW'((int'(last_grant) + k) % N);
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin data memory port sharing with locked bursts and registered responses
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_lock_i,
  input  logic [NUM_REQ*32-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]    req_wr_en_i,
  input  logic [NUM_REQ*32-1:0] req_wr_data_i,
  input  logic [NUM_REQ*4-1:0]  req_byte_en_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic [31:0]           mem_wr_data_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [31:0]           mem_rd_data_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] MAXB = (CW+1)'(MAX_BURST);
  arb_state_t state;
  logic [IW-1:0] owner, last_grant, rr_idx, win;
  logic [CW-1:0] beat_cnt;
  logic [CW:0] nxt_cnt;
  logic [NUM_REQ-1:0] rr_grant, grant;
  logic lock, wr_en, legal, xfer;
  logic [31:0] rd_fmt;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid_i),
    .last_grant(last_grant),
    .grant(rr_grant),
    .idx(rr_idx)
  );
  always_comb begin
    grant = rst ? '0 : state == BURST ? (req_valid_i[owner] ? NUM_REQ'(1) << owner : '0) : rr_grant;
    win = state == BURST ? owner : rr_idx;
    xfer = |grant;
    mem_addr_o = '0;
    mem_wr_data_o = '0;
    mem_byte_en_o = '0;
    lock = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_addr_o = req_addr_i[i*32 +: 32];
        mem_wr_data_o = req_wr_data_i[i*32 +: 32];
        mem_byte_en_o = req_byte_en_i[i*4 +: 4];
        lock = req_lock_i[i];
        wr_en = req_wr_en_i[i];
      end
    end
    legal = be_legal(mem_byte_en_o);
    mem_wr_en_o = xfer & wr_en & legal;
    rd_fmt = !legal ? BAD_BE_DATA :
             wr_en ? '0 :
             mem_byte_en_o == BE_BYTE ? {24'b0, mem_rd_data_i[7:0]} :
             mem_byte_en_o == BE_HALF ? {16'b0, mem_rd_data_i[15:0]} : mem_rd_data_i;
    nxt_cnt = {1'b0, beat_cnt} + 1'b1;
  end
  assign req_ready_o = grant;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      beat_cnt <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      rsp_valid_o <= '0;
      rsp_data_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      rsp_valid_o <= grant;
      rsp_data_o <= xfer ? rd_fmt : '0;
      rsp_err_o <= xfer & !legal;
      if (xfer) last_grant <= win;
      if (state == IDLE) begin
        if (xfer && lock && MAX_BURST > 1) begin
          state <= BURST;
          owner <= win;
          beat_cnt <= CW'(1);
        end
      end else if (req_valid_i[owner] && lock && nxt_cnt < MAXB) begin
        beat_cnt <= nxt_cnt[CW-1:0];
      end else begin
        // owner dropped valid, released the lock, or used its last allowed beat
        state <= IDLE;
        beat_cnt <= '0;
      end
    end
  end
endmodule
